// File: rtl/lot_access_controller_pkg.sv
// Shared types and defaults for the parking-lot entry gate controller.
// State encoding plus clock-rate-derived timing constants.
package lot_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        CLOSING = 2'd2
    } gate_state_t;

    localparam int CLK_HZ        = 50_000_000;
    localparam int DEF_CAPACITY  = 12;
    localparam int DEF_CNT_W     = 7;
    localparam int DEF_OPEN_CYC  = 5 * CLK_HZ;
    localparam int DEF_CLOSE_CYC = CLK_HZ;

endpackage

// File: rtl/lot_access_controller_if.sv
// Tick/request inputs and gate/occupancy outputs of the entry controller.
// master drives the ticks and request, slave is the controller.
interface lot_access_controller_if #(
    parameter int CNT_W = 7
);
    logic             enter_tick;
    logic             exit_tick;
    logic             car_waiting;
    logic             gate_open;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             denied;
    logic             tailgate;
    logic [3:0]       occ_tens;
    logic [3:0]       occ_ones;

    modport master (
        output enter_tick, exit_tick, car_waiting,
        input  gate_open, occupancy, full, empty,
        input  denied, tailgate, occ_tens, occ_ones
    );

    modport slave (
        input  enter_tick, exit_tick, car_waiting,
        output gate_open, occupancy, full, empty,
        output denied, tailgate, occ_tens, occ_ones
    );
endinterface

// File: rtl/lot_access_controller_bcd.sv
// Two-digit binary to BCD converter, purely combinational.
// Input is expected in 0..99; the tens digit is truncated above that.
module bin2bcd_2digit #(
    parameter int CNT_W = 7
) (
    input  logic [CNT_W-1:0] bin_i,
    output logic [3:0]       tens_o,
    output logic [3:0]       ones_o
);
    int val;

    always_comb begin
        val    = int'(bin_i);
        tens_o = 4'(val / 10);
        ones_o = 4'(val % 10);
    end
endmodule

// File: rtl/lot_access_controller.sv
// Entry barrier FSM with capacity enforcement and slot reservation.
// Occupancy is tracked from enter/exit ticks and shown as BCD digits.
module lot_access_controller
    import lot_pkg::*;
#(
    parameter int CAPACITY  = DEF_CAPACITY,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int OPEN_CYC  = DEF_OPEN_CYC,
    parameter int CLOSE_CYC = DEF_CLOSE_CYC
) (
    input logic                  clk,
    input logic                  rst_n,
    lot_access_controller_if.slave lot_if
);
    localparam int MAX_CYC = (OPEN_CYC > CLOSE_CYC) ? OPEN_CYC : CLOSE_CYC;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TW-1:0]    OPEN_LAST  = TW'(OPEN_CYC - 1);
    localparam logic [TW-1:0]    CLOSE_LAST = TW'(CLOSE_CYC - 1);
    localparam logic [CNT_W-1:0] CAP_W      = CNT_W'(CAPACITY);
    localparam logic [CNT_W:0]   CAP_X      = (CNT_W+1)'(CAPACITY);

    gate_state_t      state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             rsv_q, rsv_d;
    logic             cw_q;
    logic             denied_q, denied_d;
    logic             tailgate_q, tailgate_d;
    logic [CNT_W:0]   load;
    logic             full;
    logic             enter, leave;

    assign enter = lot_if.enter_tick;
    assign leave = lot_if.exit_tick;

    // The reserved slot counts as taken so an open gate blocks a second admit.
    assign load = {1'b0, occ_q} + {{CNT_W{1'b0}}, rsv_q};
    assign full = (load >= CAP_X);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rsv_d   = rsv_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (lot_if.car_waiting && !full) begin
                    state_d = OPEN;
                    rsv_d   = 1'b1;
                end
            end
            OPEN: begin
                if (enter || timer_q == OPEN_LAST) begin
                    state_d = CLOSING;
                    timer_d = '0;
                    rsv_d   = 1'b0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CLOSING: begin
                if (timer_q == CLOSE_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                rsv_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        if (enter && !leave && occ_q < CAP_W) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (leave && !enter && occ_q != '0) begin
            occ_d = occ_q - CNT_W'(1);
        end
        denied_d = (state_q == IDLE) && lot_if.car_waiting &&
                   !cw_q && full;
        tailgate_d = enter && (state_q != OPEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            occ_q      <= '0;
            rsv_q      <= 1'b0;
            cw_q       <= 1'b0;
            denied_q   <= 1'b0;
            tailgate_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            occ_q      <= occ_d;
            rsv_q      <= rsv_d;
            cw_q       <= lot_if.car_waiting;
            denied_q   <= denied_d;
            tailgate_q <= tailgate_d;
        end
    end

    assign lot_if.gate_open = (state_q == OPEN);
    assign lot_if.occupancy = occ_q;
    assign lot_if.full      = full;
    assign lot_if.empty     = (occ_q == '0);
    assign lot_if.denied    = denied_q;
    assign lot_if.tailgate  = tailgate_q;

    bin2bcd_2digit #(
        .CNT_W (CNT_W)
    ) u_bcd (
        .bin_i  (occ_q),
        .tens_o (lot_if.occ_tens),
        .ones_o (lot_if.occ_ones)
    );
endmodule

// File: tb/tb_lot_access_controller.sv
// Directed and random checks of lot_access_controller against a
// cycle-count reference model of gate phases and lot occupancy.
module tb_lot_access_controller;
    localparam int CAP = 3;
    localparam int OPC = 8;
    localparam int CLC = 4;
    localparam int CW  = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lot_access_controller_if #(.CNT_W(CW)) bus ();
    lot_access_controller_if #(.CNT_W(CW)) bus12 ();

    lot_access_controller #(
        .CAPACITY(CAP), .CNT_W(CW), .OPEN_CYC(OPC), .CLOSE_CYC(CLC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lot_if(bus.slave)
    );

    lot_access_controller #(
        .CAPACITY(12), .CNT_W(CW), .OPEN_CYC(OPC), .CLOSE_CYC(CLC)
    ) dut12 (
        .clk(clk), .rst_n(rst_n), .lot_if(bus12.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = closed/waiting, 1 = barrier up, 2 = lowering.
    int m_occ, m_rsv, m_phase, m_left, m_cwp, m_den, m_tg;

    task automatic chk(input string tag, input logic [31:0] got,
                       input int exp);
        checks++;
        assert (got === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_rsv = 0; m_phase = 0; m_left = 0;
        m_cwp = 0; m_den = 0; m_tg = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".gate"}, 32'(bus.gate_open), int'(m_phase == 1));
        chk({tag, ".occ"}, 32'(bus.occupancy), m_occ);
        chk({tag, ".full"}, 32'(bus.full), int'(m_occ + m_rsv >= CAP));
        chk({tag, ".empty"}, 32'(bus.empty), int'(m_occ == 0));
        chk({tag, ".denied"}, 32'(bus.denied), m_den);
        chk({tag, ".tailgate"}, 32'(bus.tailgate), m_tg);
        chk({tag, ".tens"}, 32'(bus.occ_tens), m_occ / 10);
        chk({tag, ".ones"}, 32'(bus.occ_ones), m_occ % 10);
    endtask

    task automatic tick(input string tag);
        int e, x, w, fullm, n_occ;
        e = int'(bus.enter_tick);
        x = int'(bus.exit_tick);
        w = int'(bus.car_waiting);
        fullm = int'(m_occ + m_rsv >= CAP);
        n_occ = m_occ;
        if (e == 1 && x == 0 && m_occ < CAP) n_occ = m_occ + 1;
        if (x == 1 && e == 0 && m_occ > 0) n_occ = m_occ - 1;
        m_den = int'(m_phase == 0 && w == 1 && m_cwp == 0 && fullm == 1);
        m_tg = int'(e == 1 && m_phase != 1);
        case (m_phase)
            0: if (w == 1 && fullm == 0) begin
                m_phase = 1; m_left = OPC; m_rsv = 1;
            end
            1: begin
                m_left--;
                if (e == 1 || m_left == 0) begin
                    m_phase = 2; m_left = CLC; m_rsv = 0;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        endcase
        @(posedge clk);
        #1;
        m_occ = n_occ;
        m_cwp = w;
        check_all(tag);
    endtask

    task automatic admit();
        bus.car_waiting = 1'b1; tick("admit_open");
        bus.car_waiting = 1'b0; tick("admit_w1");
        tick("admit_w2");
        bus.enter_tick = 1'b1; tick("admit_enter");
        bus.enter_tick = 1'b0;
        repeat (CLC) tick("admit_close");
    endtask

    initial begin
        int cnt;
        bus.enter_tick = 1'b0;
        bus.exit_tick = 1'b0;
        bus.car_waiting = 1'b0;
        bus12.enter_tick = 1'b0;
        bus12.exit_tick = 1'b0;
        bus12.car_waiting = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Timeout with no car entering
        bus.car_waiting = 1'b1; tick("to_open");
        bus.car_waiting = 1'b0;
        cnt = int'(bus.gate_open);
        repeat (13) begin
            tick("to_run");
            cnt += int'(bus.gate_open);
        end
        chk("timeout_open_cycles", 32'(cnt), OPC);
        chk("timeout_full", 32'(bus.full), 0);

        admit();
        chk("admit_occ", 32'(bus.occupancy), 1);
        admit();
        admit();
        chk("three_full", 32'(bus.full), 1);

        bus.car_waiting = 1'b1; tick("deny");
        chk("deny_pulse", 32'(bus.denied), 1);
        tick("deny_hold");
        chk("deny_once", 32'(bus.denied), 0);
        bus.exit_tick = 1'b1; tick("deny_exit");
        bus.exit_tick = 1'b0;
        tick("held_open");
        chk("held_gate", 32'(bus.gate_open), 1);
        chk("rsv_full", 32'(bus.full), 1);
        bus.exit_tick = 1'b1; tick("rsv_exit");
        bus.exit_tick = 1'b0;
        chk("rsv_release", 32'(bus.full), 0);
        bus.car_waiting = 1'b0;
        bus.enter_tick = 1'b1; tick("rsv_enter");
        bus.enter_tick = 1'b0;
        repeat (CLC) tick("rsv_close");

        bus.enter_tick = 1'b1; bus.exit_tick = 1'b1; tick("both");
        chk("both_occ", 32'(bus.occupancy), 2);
        bus.enter_tick = 1'b0;
        repeat (3) tick("drain");
        bus.exit_tick = 1'b0;
        chk("drain_empty", 32'(bus.empty), 1);
        bus.enter_tick = 1'b1;
        repeat (4) tick("tg_sat");
        bus.enter_tick = 1'b0;
        chk("tg_sat_occ", 32'(bus.occupancy), CAP);
        tick("tg_idle");

        for (int i = 0; i < 400; i++) begin
            bus.enter_tick = ($urandom_range(0, 5) == 0);
            bus.exit_tick = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.car_waiting = ~bus.car_waiting;
            tick("rand");
        end
        bus.enter_tick = 1'b0;
        bus.exit_tick = 1'b0;
        bus.car_waiting = 1'b0;

        // Asynchronous reset while the barrier is up
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        bus.enter_tick = 1'b1; tick("pre_tg");
        bus.enter_tick = 1'b0;
        bus.car_waiting = 1'b1; tick("pre_open");
        chk("pre_gate", 32'(bus.gate_open), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_gate", 32'(bus.gate_open), 0);
        chk("rst_occ", 32'(bus.occupancy), 0);
        chk("rst_full", 32'(bus.full), 0);
        bus.car_waiting = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        bus12.enter_tick = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("bcd12_occ", 32'(bus12.occupancy), 12);
        chk("bcd12_tens", 32'(bus12.occ_tens), 1);
        chk("bcd12_ones", 32'(bus12.occ_ones), 2);
        @(posedge clk);
        #1;
        bus12.enter_tick = 1'b0;
        chk("bcd12_sat", 32'(bus12.occupancy), 12);
        chk("bcd12_tg", 32'(bus12.tailgate), 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
